mac_accumulator: RTL and testbench

Sequential multiply-accumulate engine for one neuron of the network accelerator. Streams signed 8-bit input/weight pairs through a valid/ready handshake, accumulates their products onto a 32-bit bias, and presents the finished 32-bit sum for the activation stage, which performs the shift, saturation and ReLU down to 8 bits. One invocation computes one neuron; the controller reissues `start` for each neuron and layer.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/sat_add32.sv | 60 ++++++
 rtl/mac_accumulator.sv | 194 +++++++++++++++++++
 tb/tb_mac_accumulator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg
//   Shared definitions for the neuron datapath of the network accelerator.
//
//   Contents:
//     DATA_W      width of activations and weights (signed)
//     ACC_W       width of the neuron accumulator (signed)
//     PROD_W      width of one activation*weight product (signed)
//     mac_state_t control states of the multiply-accumulate engine
// ----------------------------------------------------------------------------
package nn_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/sat_add32.sv
// ----------------------------------------------------------------------------
// sat_add32
//   32-bit signed adder used as the accumulate step of mac_accumulator.
//
//   Build option:
//     MAC_SATURATE_EN defined   : result clamps to [-2^31, 2^31-1] and ovf
//                                 reports that a clamp happened.
//     MAC_SATURATE_EN undefined : result wraps in two's complement and ovf
//                                 is constant 0.
//
//   Ports:
//     a    in  ACC_W  signed addend (running accumulator)
//     b    in  ACC_W  signed addend (sign-extended product)
//     sum  out ACC_W  signed result
//     ovf  out 1      clamp indicator for this addition
// ----------------------------------------------------------------------------
module sat_add32
  import nn_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

`ifdef MAC_SATURATE_EN

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] wide;

  // One guard bit is enough: the sum of two ACC_W-bit signed values always
  // fits in ACC_W+1 bits, so the top two bits disagree exactly on overflow.
  function automatic logic sat_ovf(input logic signed [ACC_W:0] v);
    return v[ACC_W] != v[ACC_W-1];
  endfunction

  function automatic logic [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] v);
    if (!sat_ovf(v)) begin
      return v[ACC_W-1:0];
    end else if (v[ACC_W]) begin
      return ACC_MIN;
    end else begin
      return ACC_MAX;
    end
  endfunction

  assign wide = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
  assign sum  = sat_clamp(wide);
  assign ovf  = sat_ovf(wide);

`else

  assign sum = a + b;
  assign ovf = 1'b0;

`endif

endmodule

// File: rtl/mac_accumulator.sv
// ----------------------------------------------------------------------------
// mac_accumulator
//   Sequential multiply-accumulate engine for one neuron. Accepts a stream of
//   signed activation/weight pairs, accumulates their products onto a 32-bit
//   bias and presents the finished sum to the activation stage.
//
//   Build option:
//     MAC_SATURATE_EN  selects a saturating accumulate (with sticky overflow)
//                      instead of the default wrapping accumulate; the choice
//                      is made inside sat_add32.
//
//   Parameters:
//     MAX_LEN      maximum number of pairs per neuron (larger len is clamped)
//     LEN_W        width of len
//
//   Ports:
//     clk          in  1       rising-edge clock
//     reset        in  1       synchronous, active-high; aborts any neuron
//     start        in  1       begin a neuron (IDLE only), samples bias/len
//     bias         in  ACC_W   signed initial accumulator value
//     len          in  LEN_W   number of pairs, 0..MAX_LEN
//     in_valid     in  1       x/w pair valid
//     in_ready     out 1       engine accepts a pair
//     x            in  DATA_W  signed activation
//     w            in  DATA_W  signed weight
//     acc_valid    out 1       accumulator holds the final sum
//     acc_ready    in  1       downstream consumes the result
//     accumulator  out ACC_W   signed running/final sum
//     overflow     out 1       sticky clamp flag for the current neuron
//     busy         out 1       engine is not idle
//
//   Pipeline: pairs are multiplied combinationally (p0), the product is
//   registered with its valid (p1), and added to the accumulator on the
//   following edge (p2). A gap in in_valid still retires the pending product.
// ----------------------------------------------------------------------------
module mac_accumulator
  import nn_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  accumulator,
  output logic              overflow,
  output logic              busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  mac_state_t state;
  mac_state_t state_nxt;

  logic signed [PROD_W-1:0] x_p0;
  logic signed [PROD_W-1:0] w_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic                     vld_p0;

  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic        [ACC_W-1:0]  prod_ext_p1;
  logic        [ACC_W-1:0]  sum_p1;
  logic                     sum_ovf_p1;

  logic signed [ACC_W-1:0]  acc_p2;
  logic                     ovf_p2;

  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamped;
  logic             last_beat;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > MAX_LEN_V) ? MAX_LEN_V : l;
  endfunction

  assign len_clamped = clamp_len(len);

  // ---- stage p0: handshake and combinational product ----
  // Operands are widened to the product width first; the product of two
  // 8-bit signed values always fits in 16 signed bits.
  assign x_p0      = PROD_W'($signed(x));
  assign w_p0      = PROD_W'($signed(w));
  assign prod_p0   = x_p0 * w_p0;
  assign vld_p0    = in_valid & in_ready;
  assign last_beat = vld_p0 & (count == len_q - LEN_ONE);

  // ---- stage p1: registered product, sign-extended into the adder ----
  assign prod_ext_p1 = {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};

  sat_add32 u_sat_add32 (
    .a   (acc_p2),
    .b   (prod_ext_p1),
    .sum (sum_p1),
    .ovf (sum_ovf_p1)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_clamped == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last_beat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (acc_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from state only, so no input reaches an output
  // combinationally.
  always_comb begin
    in_ready  = 1'b0;
    acc_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE:    busy      = 1'b0;
      ACCUM:   in_ready  = 1'b1;
      DRAIN:   ;
      DONE:    acc_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Datapath and counters. A start only loads in IDLE; everywhere else the
  // pending product retires and a newly accepted pair becomes pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_p2  <= 1'b0;
      count   <= '0;
      len_q   <= '0;
    end else if (state == IDLE && start) begin
      acc_p2  <= bias;
      ovf_p2  <= 1'b0;
      count   <= '0;
      len_q   <= len_clamped;
      vld_p1  <= 1'b0;
    end else begin
      // ---- stage p1 -> p2: accumulate ----
      if (vld_p1) begin
        acc_p2 <= sum_p1;
        ovf_p2 <= ovf_p2 | sum_ovf_p1;
      end
      // ---- stage p0 -> p1: capture product ----
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        prod_p1 <= prod_p0;
        count   <= count + LEN_ONE;
      end
    end
  end

  assign accumulator = acc_p2;
  assign overflow    = ovf_p2;

endmodule

// File: tb/tb_mac_accumulator.sv
// ----------------------------------------------------------------------------
// tb_mac_accumulator
//   Self-checking bench for mac_accumulator. Directed neurons from the test
//   plan followed by randomized neurons; expected sums come from a plain
//   integer dot-product model (with per-step clamping when MAC_SATURATE_EN
//   is defined, wrapping otherwise).
// ----------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      bias;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       x;
  logic [7:0]       w;
  logic             acc_valid;
  logic             acc_ready;
  logic [31:0]      accumulator;
  logic             overflow;
  logic             busy;

  int tests = 0;
  int fails = 0;

  logic signed [7:0] xs [MAX_LEN];
  logic signed [7:0] ws [MAX_LEN];

  mac_accumulator #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bias        (bias),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .w           (w),
    .acc_valid   (acc_valid),
    .acc_ready   (acc_ready),
    .accumulator (accumulator),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Reference: bias plus the dot product of the first n pairs.
  function automatic void model(input logic [31:0] b, input int n,
                                output logic [31:0] res, output logic ov);
    longint s;
    s  = longint'($signed(b));
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      s += longint'(xs[i]) * longint'(ws[i]);
`ifdef MAC_SATURATE_EN
      if (s > 64'sd2147483647) begin
        s  = 64'sd2147483647;
        ov = 1'b1;
      end else if (s < -64'sd2147483648) begin
        s  = -64'sd2147483648;
        ov = 1'b1;
      end
`endif
    end
    res = s[31:0];
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      xs[i] = 8'($urandom);
      ws[i] = 8'($urandom);
    end
  endtask

  task automatic run_neuron(input string tag, input logic [31:0] b, input int l_req,
                            input int gap, input int hold,
                            input bit start_in_accum, input bit start_in_done);
    int          n;
    int          waited;
    logic [31:0] exp_acc;
    logic        exp_ov;
    n = (l_req > MAX_LEN) ? MAX_LEN : l_req;
    model(b, n, exp_acc, exp_ov);

    start = 1'b1;
    bias  = b;
    len   = LEN_W'(l_req);
    step();
    start = 1'b0;
    bias  = $urandom;
    len   = LEN_W'($urandom_range(0, 5));
    check({tag, "/busy"}, 32'(busy), 32'd1);

    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        x        = 8'($urandom);
        w        = 8'($urandom);
        step();
      end
      in_valid = 1'b1;
      x        = xs[i];
      w        = ws[i];
      if (start_in_accum && i == 1) begin
        start = 1'b1;
        len   = LEN_W'(1);
      end
      check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    x        = 8'($urandom);
    w        = 8'($urandom);

    waited = 0;
    while (acc_valid !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    check({tag, "/latency"}, 32'(waited), (n == 0) ? 32'd0 : 32'd1);
    check({tag, "/acc_valid"}, 32'(acc_valid), 32'd1);
    check({tag, "/accumulator"}, accumulator, exp_acc);
    check({tag, "/overflow"}, 32'(overflow), 32'(exp_ov));

    acc_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "/hold_acc"}, accumulator, exp_acc);
      check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/hold_valid"}, 32'(acc_valid), 32'd1);
    end

    acc_ready = 1'b1;
    if (start_in_done) begin
      start = 1'b1;
      bias  = $urandom;
      len   = LEN_W'(1);
    end
    step();
    acc_ready = 1'b0;
    start     = 1'b0;
    check({tag, "/post_valid"}, 32'(acc_valid), 32'd0);
    check({tag, "/post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    bias      = '0;
    len       = '0;
    in_valid  = 1'b0;
    x         = '0;
    w         = '0;
    acc_ready = 1'b0;
    step();
    step();
    check("reset/accumulator", accumulator, 32'd0);
    check("reset/acc_valid", 32'(acc_valid), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    step();

    // Dot product 10 + 1*4 + 2*5 + 3*6 = 42
    xs[0] = 8'sd1; xs[1] = 8'sd2; xs[2] = 8'sd3;
    ws[0] = 8'sd4; ws[1] = 8'sd5; ws[2] = 8'sd6;
    run_neuron("dot", 32'd10, 3, 0, 0, 1'b0, 1'b0);
    check("dot/value", accumulator, 32'd42);

    // Empty neuron
    run_neuron("empty", -32'sd5, 0, 0, 0, 1'b0, 1'b0);

    // Stalls and backpressure: 4 * 16384 = 65536
    for (int i = 0; i < 4; i++) begin
      xs[i] = -8'sd128;
      ws[i] = -8'sd128;
    end
    run_neuron("stall", 32'd0, 4, 2, 5, 1'b0, 1'b0);

    // Overflow corner
    xs[0] = 8'sd127;
    ws[0] = 8'sd127;
    run_neuron("ovf", 32'd2147483000, 1, 0, 1, 1'b0, 1'b0);

    // Reset mid-ACCUM after 2 of 5 beats
    fill_random(5);
    start = 1'b1;
    bias  = $urandom;
    len   = LEN_W'(5);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x        = xs[i];
      w        = ws[i];
      step();
    end
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("midrst/accumulator", accumulator, 32'd0);
    check("midrst/acc_valid", 32'(acc_valid), 32'd0);
    check("midrst/in_ready", 32'(in_ready), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      step();
      check("midrst/idle_valid", 32'(acc_valid), 32'd0);
    end
    in_valid = 1'b0;
    xs[0] = 8'sd2;
    ws[0] = 8'sd3;
    run_neuron("fresh", 32'd0, 1, 0, 0, 1'b0, 1'b0);
    check("fresh/value", accumulator, 32'd6);

    // start pulses during ACCUM and during the DONE handshake
    fill_random(6);
    run_neuron("pulse", $urandom, 6, 0, 2, 1'b1, 1'b1);

    // Maximum and over-maximum length
    fill_random(MAX_LEN);
    run_neuron("maxlen", $urandom, MAX_LEN, 0, 0, 1'b0, 1'b0);
    fill_random(MAX_LEN);
    run_neuron("clamplen", $urandom, 300, 0, 0, 1'b0, 1'b0);

    // Randomized neurons, some with biases near the rails
    for (int t = 0; t < 16; t++) begin
      int          l;
      logic [31:0] b;
      l = $urandom_range(0, 12);
      case ($urandom_range(0, 2))
        0:       b = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
        1:       b = 32'h8000_0000 + 32'($urandom_range(0, 65535));
        default: b = $urandom;
      endcase
      fill_random(l);
      run_neuron("random", b, l, $urandom_range(0, 1), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
